// File: rtl/tri_sched_pkg.sv
// Shared types and constants for the triangle job scheduler.
package tri_sched_pkg;

  localparam int CNT_W_DEF = 7;

  // Vertex field LSB positions inside the 18-bit {x1,y1,x2,y2,x3,y3} job word
  localparam int X1_LSB = 15;
  localparam int Y1_LSB = 12;
  localparam int X2_LSB = 9;
  localparam int Y2_LSB = 6;
  localparam int X3_LSB = 3;
  localparam int Y3_LSB = 0;

  typedef enum logic [3:0] {
    IDLE, SEND0, SEND1, SEND2, WAIT_BUSY, RUN, FIN, REJ0, REJ1
  } state_t;

  function automatic logic [2:0] fld(input logic [17:0] w, input int lsb);
    return w[lsb +: 3];
  endfunction

  function automatic logic job_ok(input logic [17:0] w);
    return (fld(w, Y1_LSB) == fld(w, Y2_LSB)) &&
           (fld(w, X1_LSB) <= fld(w, X2_LSB)) &&
           (fld(w, Y3_LSB) >  fld(w, Y1_LSB));
  endfunction

endpackage

// File: rtl/tri_rr_arb.sv
// Two-way round-robin arbiter; on a tie the requester other than last_id wins.
module tri_rr_arb (
  input  logic [1:0] req,
  input  logic       last_id,
  input  logic       en,
  output logic [1:0] gnt
);

  assign gnt[0] = en & req[0] & (~req[1] | last_id);
  assign gnt[1] = en & req[1] & (~req[0] | ~last_id);

endmodule

// File: rtl/tri_job_sched.sv
// Triangle job scheduler: arbitrates two requesters, loads the rasterizer, forwards pixels.
// Optional job validation is enabled with `define TRI_SCHED_VALID_EN.
//   state     | meaning
//   IDLE      | arbitrate, latch winner, drive x1/y1 with ras_nt
//   SEND0/1/2 | vertex 1/2/3 on ras_xi/yi
//   WAIT_BUSY | wait for rasterizer to go busy
//   RUN       | forward pixels until busy drops
//   FIN       | done pulse, clear counter, update pointer
//   REJ0/1    | rejected job delay before FIN (validation only)
module tri_job_sched
  import tri_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [17:0]      tri0_data,
  input  logic [17:0]      tri1_data,
  output logic [1:0]       gnt,
  output logic             ras_nt,
  output logic [2:0]       ras_xi,
  output logic [2:0]       ras_yi,
  input  logic             ras_busy,
  input  logic             ras_po,
  input  logic [2:0]       ras_xo,
  input  logic [2:0]       ras_yo,
  output logic             pix_valid,
  output logic [2:0]       pix_x,
  output logic [2:0]       pix_y,
  output logic             pix_id,
  output logic             done,
  output logic             done_id,
  output logic [CNT_W-1:0] done_cnt,
  output logic             done_err
);

  state_t           state_q, state_d;
  logic [11:0]      data_q, data_d;
  logic             id_q, id_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       arb_gnt;
  logic [17:0]      w_data;
  logic             issue;

  logic [1:0]       gnt_d;
  logic             ras_nt_d, pix_valid_d, pix_id_d, done_d, done_id_d, done_err_d;
  logic [2:0]       ras_xi_d, ras_yi_d, pix_x_d, pix_y_d;
  logic [CNT_W-1:0] done_cnt_d;

`ifdef TRI_SCHED_VALID_EN
  logic err_q, err_d;
`endif

  tri_rr_arb u_arb (
    .req     (req),
    .last_id (last_q),
    .en      (state_q == IDLE),
    .gnt     (arb_gnt)
  );

  assign w_data = arb_gnt[1] ? tri1_data : tri0_data;

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    id_d        = id_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    issue       = 1'b1;
    gnt_d       = 2'b00;
    ras_nt_d    = 1'b0;
    ras_xi_d    = ras_xi;
    ras_yi_d    = ras_yi;
    pix_valid_d = 1'b0;
    pix_x_d     = pix_x;
    pix_y_d     = pix_y;
    pix_id_d    = pix_id;
    done_d      = 1'b0;
    done_id_d   = done_id;
    done_cnt_d  = done_cnt;
    done_err_d  = 1'b0;
`ifdef TRI_SCHED_VALID_EN
    err_d       = err_q;
`endif

    // Pixels are forwarded in WAIT_BUSY and RUN, including the cycle busy falls
    if ((state_q == WAIT_BUSY || state_q == RUN) && ras_po) begin
      pix_valid_d = 1'b1;
      pix_x_d     = ras_xo;
      pix_y_d     = ras_yo;
      pix_id_d    = id_q;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (|arb_gnt) begin
          data_d = w_data[11:0];
          id_d   = arb_gnt[1];
          gnt_d  = arb_gnt;
          cnt_d  = '0;
`ifdef TRI_SCHED_VALID_EN
          issue  = job_ok(w_data);
          err_d  = ~issue;
`endif
          if (issue) begin
            state_d  = SEND0;
            ras_nt_d = 1'b1;
            ras_xi_d = fld(w_data, X1_LSB);
            ras_yi_d = fld(w_data, Y1_LSB);
          end else begin
            state_d  = REJ0;
          end
        end
      end
      SEND0: begin
        ras_xi_d = fld({6'd0, data_q}, X2_LSB);
        ras_yi_d = fld({6'd0, data_q}, Y2_LSB);
        state_d  = SEND1;
      end
      SEND1: begin
        ras_xi_d = fld({6'd0, data_q}, X3_LSB);
        ras_yi_d = fld({6'd0, data_q}, Y3_LSB);
        state_d  = SEND2;
      end
      SEND2:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (ras_busy) state_d = RUN;
      RUN: begin
        if (!ras_busy) begin
          state_d    = FIN;
          done_d     = 1'b1;
          done_id_d  = id_q;
          done_cnt_d = cnt_d;
        end
      end
      REJ0:      state_d = REJ1;
      REJ1: begin
        state_d    = FIN;
        done_d     = 1'b1;
        done_id_d  = id_q;
        done_cnt_d = cnt_q;
`ifdef TRI_SCHED_VALID_EN
        done_err_d = err_q;
`endif
      end
      FIN: begin
        cnt_d   = '0;
        last_d  = id_q;
        state_d = IDLE;
`ifdef TRI_SCHED_VALID_EN
        err_d   = 1'b0;
`endif
      end
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      data_q    <= '0;
      id_q      <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      gnt       <= 2'b00;
      ras_nt    <= 1'b0;
      ras_xi    <= '0;
      ras_yi    <= '0;
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_id    <= 1'b0;
      done      <= 1'b0;
      done_id   <= 1'b0;
      done_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      id_q      <= id_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      gnt       <= gnt_d;
      ras_nt    <= ras_nt_d;
      ras_xi    <= ras_xi_d;
      ras_yi    <= ras_yi_d;
      pix_valid <= pix_valid_d;
      pix_x     <= pix_x_d;
      pix_y     <= pix_y_d;
      pix_id    <= pix_id_d;
      done      <= done_d;
      done_id   <= done_id_d;
      done_cnt  <= done_cnt_d;
    end
  end

`ifdef TRI_SCHED_VALID_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q    <= 1'b0;
      done_err <= 1'b0;
    end else begin
      err_q    <= err_d;
      done_err <= done_err_d;
    end
  end
`else
  assign done_err = 1'b0;
`endif

endmodule

// File: tb/tb_tri_job_sched.sv
// Directed bench for tri_job_sched: table of jobs plus reset-abort and rejection sequences.
module tb_tri_job_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [17:0] tri0_data, tri1_data;
  logic        ras_busy, ras_po;
  logic [2:0]  ras_xo, ras_yo;

  logic [1:0]  gnt, gnt3;
  logic        ras_nt, ras_nt3, pix_valid, pix_valid3, pix_id, pix_id3;
  logic [2:0]  ras_xi, ras_yi, pix_x, pix_y, ras_xi3, ras_yi3, pix_x3, pix_y3;
  logic        done, done_id, done_err, done3, done_id3, done_err3;
  logic [6:0]  done_cnt;
  logic [2:0]  done_cnt3;

  tri_job_sched u_dut (
    .clk(clk), .reset(reset), .req(req), .tri0_data(tri0_data), .tri1_data(tri1_data),
    .gnt(gnt), .ras_nt(ras_nt), .ras_xi(ras_xi), .ras_yi(ras_yi),
    .ras_busy(ras_busy), .ras_po(ras_po), .ras_xo(ras_xo), .ras_yo(ras_yo),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_id(pix_id),
    .done(done), .done_id(done_id), .done_cnt(done_cnt), .done_err(done_err)
  );

  tri_job_sched #(.CNT_W(3)) u_dut3 (
    .clk(clk), .reset(reset), .req(req), .tri0_data(tri0_data), .tri1_data(tri1_data),
    .gnt(gnt3), .ras_nt(ras_nt3), .ras_xi(ras_xi3), .ras_yi(ras_yi3),
    .ras_busy(ras_busy), .ras_po(ras_po), .ras_xo(ras_xo), .ras_yo(ras_yo),
    .pix_valid(pix_valid3), .pix_x(pix_x3), .pix_y(pix_y3), .pix_id(pix_id3),
    .done(done3), .done_id(done_id3), .done_cnt(done_cnt3), .done_err(done_err3)
  );

  always #5 clk = ~clk;

  // (0,0),(4,0),(0,4) and (1,2),(5,2),(3,6): both pass validation
  localparam logic [17:0] JOB0 = {3'd0, 3'd0, 3'd4, 3'd0, 3'd0, 3'd4};
  localparam logic [17:0] JOB1 = {3'd1, 3'd2, 3'd5, 3'd2, 3'd3, 3'd6};

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0] req;
    logic [1:0] exp_gnt;
    int         npix;
    bit         fall;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] vtx(input logic [17:0] w, input int k);
    logic [17:0] t;
    t = w >> (12 - 6 * k);
    return t[5:0];
  endfunction

  task automatic run_job(input logic [1:0] r, input logic [1:0] eg, input int npix,
                         input bit fall, input string tag);
    logic [17:0] w;
    logic        id;
    logic [2:0]  ex, ey;
    int          c7, c3;
    id = eg[1];
    w  = id ? tri1_data : tri0_data;
    req = r;
    tick;
    req = req & ~eg;
    chk({tag, " gnt"}, 32'(gnt), 32'(eg));
    chk({tag, " nt0"}, 32'(ras_nt), 32'd1);
    chk({tag, " v1"}, 32'({ras_xi, ras_yi}), 32'(vtx(w, 0)));
    tick;
    chk({tag, " gnt_pulse"}, 32'(gnt), 32'd0);
    chk({tag, " nt1"}, 32'(ras_nt), 32'd0);
    chk({tag, " v2"}, 32'({ras_xi, ras_yi}), 32'(vtx(w, 1)));
    tick;
    chk({tag, " v3"}, 32'({ras_xi, ras_yi}), 32'(vtx(w, 2)));
    tick;
    ras_busy = 1'b1;
    tick;
    for (int k = 0; k < npix; k++) begin
      ex = 3'(k);
      ey = 3'(k >> 3);
      ras_po = 1'b1;
      ras_xo = ex;
      ras_yo = ey;
      ras_busy = !(fall && k == npix - 1);
      tick;
      chk({tag, " pix_valid"}, 32'(pix_valid), 32'd1);
      chk({tag, " pix"}, 32'({pix_id, pix_x, pix_y}), 32'({id, ex, ey}));
      if (!(fall && k == npix - 1)) chk({tag, " early_done"}, 32'(done), 32'd0);
    end
    ras_po = 1'b0;
    if (!fall) begin
      ras_busy = 1'b0;
      tick;
    end
    c7 = (npix > 127) ? 127 : npix;
    c3 = (npix > 7) ? 7 : npix;
    chk({tag, " done"}, 32'({done, done3}), 32'b11);
    chk({tag, " done_id"}, 32'(done_id), 32'(id));
    chk({tag, " done_cnt"}, 32'(done_cnt), 32'(c7));
    chk({tag, " done_cnt_sat"}, 32'(done_cnt3), 32'(c3));
    chk({tag, " done_err"}, 32'(done_err), 32'd0);
    ras_busy = 1'b0;
    tick;
    chk({tag, " done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " outs"}, 32'({gnt, ras_nt, ras_xi, ras_yi, pix_valid, pix_x, pix_y, pix_id,
                             done, done_id, done_err}), 32'd0);
    chk({tag, " cnt"}, 32'(done_cnt), 32'd0);
    chk({tag, " outs3"}, 32'({gnt3, ras_nt3, ras_xi3, ras_yi3, pix_valid3, pix_x3, pix_y3,
                              pix_id3, done3, done_id3, done_err3, done_cnt3}), 32'd0);
  endtask

  initial begin
    vecs[0] = '{req: 2'b11, exp_gnt: 2'b01, npix: 15, fall: 1'b0};
    vecs[1] = '{req: 2'b11, exp_gnt: 2'b10, npix: 4,  fall: 1'b1};
    vecs[2] = '{req: 2'b10, exp_gnt: 2'b10, npix: 0,  fall: 1'b0};
    vecs[3] = '{req: 2'b11, exp_gnt: 2'b01, npix: 8,  fall: 1'b1};
    vecs[4] = '{req: 2'b01, exp_gnt: 2'b01, npix: 64, fall: 1'b0};
    vecs[5] = '{req: 2'b11, exp_gnt: 2'b10, npix: 1,  fall: 1'b1};

    reset = 1'b1;
    req = 2'b00;
    tri0_data = JOB0;
    tri1_data = JOB1;
    ras_busy = 1'b0;
    ras_po = 1'b0;
    ras_xo = 3'd0;
    ras_yo = 3'd0;
    tick;
    tick;
    chk_all_zero("reset");
    reset = 1'b0;
    tick;

    for (int i = 0; i < 6; i++)
      run_job(vecs[i].req, vecs[i].exp_gnt, vecs[i].npix, vecs[i].fall, $sformatf("vec%0d", i));

    // Reset in RUN after five pixels aborts the job with no done
    req = 2'b01;
    tick;
    chk("abort gnt", 32'(gnt), 32'b01);
    req = 2'b00;
    tick;
    tick;
    tick;
    ras_busy = 1'b1;
    tick;
    for (int k = 0; k < 5; k++) begin
      ras_po = 1'b1;
      ras_xo = 3'(k);
      tick;
    end
    chk("abort pix_valid", 32'(pix_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk_all_zero("abort");
    ras_po = 1'b0;
    ras_busy = 1'b0;
    tick;
    chk("abort no_done", 32'(done), 32'd0);
    reset = 1'b0;
    tick;
    run_job(2'b11, 2'b01, 3, 1'b0, "post_reset");

`ifdef TRI_SCHED_VALID_EN
    // (0,0),(4,1),(0,4) fails y1==y2: granted, never issued, done_err two cycles after gnt
    tri0_data = {3'd0, 3'd0, 3'd4, 3'd1, 3'd0, 3'd4};
    req = 2'b01;
    tick;
    chk("rej gnt", 32'(gnt), 32'b01);
    chk("rej nt_a", 32'(ras_nt), 32'd0);
    req = 2'b00;
    tick;
    chk("rej early", 32'({done, ras_nt}), 32'd0);
    tick;
    chk("rej done", 32'({done, done_err, ras_nt}), 32'b110);
    chk("rej cnt", 32'(done_cnt), 32'd0);
    tick;
    chk("rej pulse", 32'({done, done_err, ras_nt}), 32'd0);
    tri0_data = JOB0;
    tick;
    run_job(2'b11, 2'b10, 2, 1'b1, "after_rej");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
